// File: rtl/nf2_dma_sys_ctrl_if.sv
// Bus bundle for the system-side DMA sequencer: TX async FIFO read side,
// RX async FIFO write side, CPU TX/RX queue strobes and status pulses.
interface nf2_dma_sys_ctrl_if #(
    parameter int DMA_DATA_WIDTH = 32,
    parameter int NUM_CPU_QUEUES = 4
);
    localparam int W = DMA_DATA_WIDTH;
    localparam int N = NUM_CPU_QUEUES;

    logic                 txfifo_empty;
    logic [W+4:0]         txfifo_rd_data;
    logic                 txfifo_rd_inc;
    logic                 rxfifo_full;
    logic                 rxfifo_wr;
    logic [W+2:0]         rxfifo_wr_data;
    logic [N-1:0]         tx_q_wr;
    logic [W+2:0]         tx_q_wr_data;
    logic [N-1:0]         tx_q_full;
    logic [N-1:0]         rx_q_rd;
    logic [N*(W+3)-1:0]   rx_q_rd_data;
    logic [N-1:0]         rx_q_empty;
    logic                 tx_pkt_done;
    logic                 rx_pkt_done;
    logic                 err_req;
    logic                 err_fmt;

    modport master (
        input  txfifo_empty, txfifo_rd_data, rxfifo_full, tx_q_full,
               rx_q_rd_data, rx_q_empty,
        output txfifo_rd_inc, rxfifo_wr, rxfifo_wr_data, tx_q_wr, tx_q_wr_data,
               rx_q_rd, tx_pkt_done, rx_pkt_done, err_req, err_fmt
    );

    modport slave (
        output txfifo_empty, txfifo_rd_data, rxfifo_full, tx_q_full,
               rx_q_rd_data, rx_q_empty,
        input  txfifo_rd_inc, rxfifo_wr, rxfifo_wr_data, tx_q_wr, tx_q_wr_data,
               rx_q_rd, tx_pkt_done, rx_pkt_done, err_req, err_fmt
    );
endinterface

// File: rtl/nf2_dma_sys_ctrl.sv
// System-clock DMA sequencer: decodes host request words and steers packets
// between the host async FIFOs and the CPU queues, with length/format policing.
module nf2_dma_sys_ctrl #(
    parameter int DMA_DATA_WIDTH = 32,
    parameter int NUM_CPU_QUEUES = 4,
    parameter int MAX_PKT_WORDS  = 512
) (
    input  logic               clk,
    input  logic               reset_n,
    nf2_dma_sys_ctrl_if.master bus
);
    localparam int W = DMA_DATA_WIDTH;
    localparam int N = NUM_CPU_QUEUES;
    localparam logic [10:0] MAX_CNT = 11'(MAX_PKT_WORDS);

    typedef enum logic [1:0] {IDLE, TX_PKT, RX_PKT, DRAIN} state_t;

    state_t      state;
    logic [3:0]  sel;
    logic [10:0] word_cnt;

    logic         head_valid;
    logic         head_req;
    logic         head_eop;
    logic [3:0]   head_qid;
    logic         qid_ok;
    logic [N-1:0] sel_oh;
    logic [W+2:0] rx_slice;
    logic         tx_full_sel;
    logic         rx_empty_sel;
    logic         last_word;
    logic         tx_move;
    logic         rx_move;

    logic         pop;
    logic         rx_wr;
    logic [W+2:0] rx_data;
    logic [N-1:0] txq_wr;
    logic [W+2:0] tx_data;
    logic [N-1:0] rxq_rd;
    logic         tx_done;
    logic         rx_done;
    logic         e_req;
    logic         e_fmt;

    always_comb begin
        head_valid = !bus.txfifo_empty;
        head_req   = bus.txfifo_rd_data[W+3];
        head_eop   = bus.txfifo_rd_data[W+2];
        head_qid   = bus.txfifo_rd_data[3:0];
        qid_ok     = int'(head_qid) < N;
        sel_oh     = '0;
        rx_slice   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            sel_oh[i] = (sel == 4'(i));
            if (sel == 4'(i)) rx_slice = bus.rx_q_rd_data[i*(W+3) +: W+3];
        end
        tx_full_sel  = |(bus.tx_q_full & sel_oh);
        rx_empty_sel = |(bus.rx_q_empty & sel_oh);
        last_word    = (word_cnt + 11'd1) == MAX_CNT;
        tx_move      = (state == TX_PKT) && head_valid && !head_req && !tx_full_sel;
        rx_move      = (state == RX_PKT) && !rx_empty_sel && !bus.rxfifo_full;
    end

    // Strobes are zero-latency against FWFT heads, so they stay combinational;
    // reset_n gates them so nothing leaks out while the domain is held in reset.
    always_comb begin
        pop     = 1'b0;
        rx_wr   = 1'b0;
        rx_data = '0;
        txq_wr  = '0;
        tx_data = '0;
        rxq_rd  = '0;
        tx_done = 1'b0;
        rx_done = 1'b0;
        e_req   = 1'b0;
        e_fmt   = 1'b0;
        if (reset_n) begin
            case (state)
                IDLE: begin
                    if (head_valid) begin
                        pop = 1'b1;
                        if (!head_req)    e_fmt = 1'b1;
                        else if (!qid_ok) e_req = 1'b1;
                    end
                end
                TX_PKT: begin
                    if (head_valid && head_req) begin
                        e_fmt = 1'b1;
                    end else if (tx_move) begin
                        pop     = 1'b1;
                        txq_wr  = sel_oh;
                        tx_data = bus.txfifo_rd_data[W+2:0];
                        if (head_eop)       tx_done = 1'b1;
                        else if (last_word) e_fmt   = 1'b1;
                    end
                end
                RX_PKT: begin
                    if (rx_move) begin
                        rxq_rd  = sel_oh;
                        rx_wr   = 1'b1;
                        rx_data = rx_slice;
                        if (rx_slice[W+2]) begin
                            rx_done = 1'b1;
                        end else if (last_word) begin
                            rx_data[W+2] = 1'b1;
                            e_fmt        = 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (head_valid && !head_req) pop = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            sel      <= '0;
            word_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (head_valid && head_req) begin
                        if (qid_ok) begin
                            sel      <= head_qid;
                            word_cnt <= '0;
                            state    <= head_eop ? RX_PKT : TX_PKT;
                        end else if (!head_eop) begin
                            state <= DRAIN;
                        end
                    end
                end
                TX_PKT: begin
                    // A request at the head truncates the packet but is left for IDLE
                    if (head_valid && head_req) begin
                        state <= IDLE;
                    end else if (tx_move) begin
                        word_cnt <= word_cnt + 11'd1;
                        if (head_eop)       state <= IDLE;
                        else if (last_word) state <= DRAIN;
                    end
                end
                RX_PKT: begin
                    if (rx_move) begin
                        word_cnt <= word_cnt + 11'd1;
                        if (rx_slice[W+2] || last_word) state <= IDLE;
                    end
                end
                DRAIN: begin
                    if (head_valid && (head_req || head_eop)) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.txfifo_rd_inc  = pop;
    assign bus.rxfifo_wr      = rx_wr;
    assign bus.rxfifo_wr_data = rx_data;
    assign bus.tx_q_wr        = txq_wr;
    assign bus.tx_q_wr_data   = tx_data;
    assign bus.rx_q_rd        = rxq_rd;
    assign bus.tx_pkt_done    = tx_done;
    assign bus.rx_pkt_done    = rx_done;
    assign bus.err_req        = e_req;
    assign bus.err_fmt        = e_fmt;
endmodule

// File: tb/tb_nf2_dma_sys_ctrl.sv
// Bench for nf2_dma_sys_ctrl: directed scenarios plus a randomized stream,
// checked against a packet-level stream parser model.
module tb_nf2_dma_sys_ctrl;
    localparam int W   = 32;
    localparam int N   = 4;
    localparam int MAX = 4;
    localparam int DW  = W + 3;
    localparam int HW  = W + 5;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    nf2_dma_sys_ctrl_if #(.DMA_DATA_WIDTH(W), .NUM_CPU_QUEUES(N)) bus ();

    nf2_dma_sys_ctrl #(
        .DMA_DATA_WIDTH(W),
        .NUM_CPU_QUEUES(N),
        .MAX_PKT_WORDS (MAX)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [HW-1:0] tx_stream[$];
    logic [DW-1:0] rxq[N][$];
    logic [DW-1:0] got_tx[N][$];
    logic [DW-1:0] exp_tx[N][$];
    logic [DW-1:0] got_rx[$];
    logic [DW-1:0] exp_rx[$];
    int got_txdone, got_rxdone, got_ereq, got_efmt;
    int exp_txdone, exp_rxdone, exp_ereq, exp_efmt;
    int cyc, stall_pct, full_lo, full_hi;
    int tx_wr_cyc[$], rx_wr_cyc[$], txdone_cyc[$], rxdone_cyc[$], pop_cyc[$];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [HW-1:0] req(input bit dir, input int qid);
        return {1'b0, 1'b1, dir, 2'b00, W'(qid)};
    endfunction

    function automatic logic [HW-1:0] dat(input bit eop, input logic [1:0] bc, input logic [W-1:0] d);
        return {1'b0, 1'b0, eop, bc, d};
    endfunction

    function automatic logic [DW-1:0] rxw(input bit eop, input logic [1:0] bc, input logic [W-1:0] d);
        return {eop, bc, d};
    endfunction

    function automatic int qat(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    function automatic logic [2*DW+2*N+5:0] outs();
        return {bus.txfifo_rd_inc, bus.rxfifo_wr, bus.rxfifo_wr_data, bus.tx_q_wr,
                bus.tx_q_wr_data, bus.rx_q_rd, bus.tx_pkt_done, bus.rx_pkt_done,
                bus.err_req, bus.err_fmt};
    endfunction

    function automatic bit rnd(input int pct);
        return int'($urandom_range(99)) < pct;
    endfunction

    task automatic drive();
        bus.txfifo_empty   = (tx_stream.size() == 0) || rnd(stall_pct);
        bus.txfifo_rd_data = (tx_stream.size() != 0) ? tx_stream[0] : '0;
        bus.rxfifo_full    = rnd(stall_pct) || (cyc >= full_lo && cyc <= full_hi);
        for (int i = 0; i < N; i++) begin
            bus.tx_q_full[i]  = rnd(stall_pct);
            bus.rx_q_empty[i] = (rxq[i].size() == 0) || rnd(stall_pct);
            bus.rx_q_rd_data[i*DW +: DW] = (rxq[i].size() != 0) ? rxq[i][0] : '0;
        end
    endtask

    task automatic sample();
        if (bus.txfifo_rd_inc) begin
            check("pop_when_valid", bus.txfifo_empty, 1'b0);
            if (tx_stream.size() != 0) void'(tx_stream.pop_front());
            pop_cyc.push_back(cyc);
        end
        if (bus.tx_q_wr != '0) begin
            check("tx_wr_onehot_not_full", {$onehot(bus.tx_q_wr), |(bus.tx_q_wr & bus.tx_q_full)}, 2'b10);
            for (int i = 0; i < N; i++)
                if (bus.tx_q_wr[i]) got_tx[i].push_back(bus.tx_q_wr_data);
            tx_wr_cyc.push_back(cyc);
        end
        if (bus.rx_q_rd != '0 || bus.rxfifo_wr) begin
            check("rx_rd_wr_paired", {$onehot(bus.rx_q_rd), bus.rxfifo_wr,
                  |(bus.rx_q_rd & bus.rx_q_empty), bus.rxfifo_full}, 4'b1100);
            got_rx.push_back(bus.rxfifo_wr_data);
            for (int i = 0; i < N; i++)
                if (bus.rx_q_rd[i] && rxq[i].size() != 0) void'(rxq[i].pop_front());
            rx_wr_cyc.push_back(cyc);
        end
        if (bus.tx_pkt_done) begin got_txdone++; txdone_cyc.push_back(cyc); end
        if (bus.rx_pkt_done) begin got_rxdone++; rxdone_cyc.push_back(cyc); end
        if (bus.err_req) got_ereq++;
        if (bus.err_fmt) got_efmt++;
    endtask

    task automatic step();
        @(negedge clk);
        drive();
        #1;
        sample();
        cyc++;
    endtask

    task automatic clear_all();
        tx_stream.delete();
        for (int i = 0; i < N; i++) begin
            rxq[i].delete(); got_tx[i].delete(); exp_tx[i].delete();
        end
        got_rx.delete(); exp_rx.delete();
        tx_wr_cyc.delete(); rx_wr_cyc.delete(); txdone_cyc.delete();
        rxdone_cyc.delete(); pop_cyc.delete();
        got_txdone = 0; got_rxdone = 0; got_ereq = 0; got_efmt = 0;
        cyc = 0; full_lo = -1; full_hi = -1;
    endtask

    // Walks the host word stream packet by packet and predicts every queue's contents
    task automatic build_expected();
        logic [HW-1:0] s[$];
        logic [DW-1:0] q[N][$];
        logic [HW-1:0] w;
        logic [DW-1:0] v;
        int p, n, qid;
        bit drain, closed;
        s = tx_stream;
        for (int i = 0; i < N; i++) begin q[i] = rxq[i]; exp_tx[i].delete(); end
        exp_rx.delete();
        exp_txdone = 0; exp_rxdone = 0; exp_ereq = 0; exp_efmt = 0;
        p = 0; drain = 0;
        while (p < s.size()) begin
            w = s[p];
            if (drain) begin
                if (w[W+3]) drain = 0;
                else begin p++; drain = !w[W+2]; end
            end else if (!w[W+3]) begin
                exp_efmt++; p++;
            end else begin
                qid = int'(w[3:0]);
                p++;
                if (qid >= N) begin
                    exp_ereq++;
                    drain = !w[W+2];
                end else if (!w[W+2]) begin
                    n = 0; closed = 0;
                    while (!closed && p < s.size() && !s[p][W+3]) begin
                        w = s[p]; p++;
                        exp_tx[qid].push_back(w[DW-1:0]);
                        n++;
                        if (w[W+2]) begin exp_txdone++; closed = 1; end
                        else if (n == MAX) begin exp_efmt++; drain = 1; closed = 1; end
                    end
                    if (!closed && p < s.size()) exp_efmt++;
                end else begin
                    n = 0; closed = 0;
                    while (!closed && q[qid].size() != 0) begin
                        v = q[qid].pop_front();
                        n++;
                        if (v[DW-1]) begin exp_rxdone++; closed = 1; end
                        else if (n == MAX) begin v[DW-1] = 1'b1; exp_efmt++; closed = 1; end
                        exp_rx.push_back(v);
                    end
                end
            end
        end
    endtask

    function automatic bit tx_sizes_match();
        bit m = 1;
        for (int i = 0; i < N; i++) if (got_tx[i].size() != exp_tx[i].size()) m = 0;
        return m;
    endfunction

    task automatic run_and_check(input string name, input int budget);
        bit done;
        int k;
        build_expected();
        cyc = 0;
        done = 0;
        for (int c = 0; c < budget && !done; c++) begin
            step();
            done = (tx_stream.size() == 0) && (got_rx.size() == exp_rx.size()) && tx_sizes_match();
        end
        check({name, "_finished"}, done, 1'b1);
        repeat (4) step();
        for (int i = 0; i < N; i++) begin
            check({name, "_txq_count"}, got_tx[i].size(), exp_tx[i].size());
            k = (got_tx[i].size() < exp_tx[i].size()) ? got_tx[i].size() : exp_tx[i].size();
            for (int j = 0; j < k; j++) check({name, "_txq_data"}, got_tx[i][j], exp_tx[i][j]);
        end
        check({name, "_rx_count"}, got_rx.size(), exp_rx.size());
        k = (got_rx.size() < exp_rx.size()) ? got_rx.size() : exp_rx.size();
        for (int j = 0; j < k; j++) check({name, "_rx_data"}, got_rx[j], exp_rx[j]);
        check({name, "_pulses"}, {got_txdone, got_rxdone, got_ereq, got_efmt},
              {exp_txdone, exp_rxdone, exp_ereq, exp_efmt});
    endtask

    initial begin
        int kind, qid, len;
        stall_pct = 0;
        clear_all();

        // Reset: outputs held at zero even with a valid request at the head
        tx_stream.push_back(req(0, 1));
        rxq[0].push_back(rxw(1, 2'd0, 32'h5));
        repeat (2) begin
            @(negedge clk);
            drive();
            #1;
            check("reset_outputs", outs(), '0);
        end
        clear_all();
        @(negedge clk);
        reset_n = 1'b1;
        drive();
        #1;
        check("idle_outputs", outs(), '0);

        // TX to queue 2, 3 words
        clear_all();
        tx_stream = '{req(0, 2), dat(0, 2'd0, $urandom()), dat(0, 2'd1, $urandom()),
                      dat(1, 2'b11, $urandom())};
        run_and_check("tx", 50);
        check("tx_wr_cycles", {qat(tx_wr_cyc, 0), qat(tx_wr_cyc, 1), qat(tx_wr_cyc, 2), tx_wr_cyc.size()},
              {32'd1, 32'd2, 32'd3, 32'd3});
        check("tx_done_cycle", {qat(txdone_cyc, 0), txdone_cyc.size()}, {32'd3, 32'd1});

        // RX from queue 1 with the host FIFO full on cycles 2-3
        clear_all();
        for (int i = 0; i < 4; i++) rxq[1].push_back(rxw(i == 3, 2'(i), $urandom()));
        tx_stream = '{req(1, 1)};
        full_lo = 2;
        full_hi = 3;
        run_and_check("rx_stall", 50);
        check("rx_wr_cycles", {qat(rx_wr_cyc, 0), qat(rx_wr_cyc, 1), qat(rx_wr_cyc, 2), qat(rx_wr_cyc, 3)},
              {32'd1, 32'd4, 32'd5, 32'd6});
        check("rx_done_cycle", qat(rxdone_cyc, 0), 32'd6);

        // Bad qid with a drained packet, then RX from queue 0
        clear_all();
        rxq[0] = '{rxw(0, 2'd0, $urandom()), rxw(1, 2'd1, $urandom())};
        tx_stream = '{req(0, 7), dat(0, 2'd0, $urandom()), dat(1, 2'd0, $urandom()), req(1, 0)};
        run_and_check("bad_qid", 50);
        check("bad_qid_pops", pop_cyc.size(), 32'd4);

        // Truncated TX packet followed by a packet to queue 3
        clear_all();
        tx_stream = '{req(0, 0), dat(0, 2'd0, $urandom()), req(0, 3), dat(1, 2'd2, $urandom())};
        run_and_check("trunc", 50);

        // Over-length RX: 6 words without eop
        clear_all();
        for (int i = 0; i < 6; i++) rxq[2].push_back(rxw(0, 2'd0, $urandom()));
        tx_stream = '{req(1, 2)};
        run_and_check("ovl", 50);
        check("ovl_left_in_queue", rxq[2].size(), 32'd2);
        check("ovl_writes", got_rx.size(), 32'd4);

        // Reset in the middle of an RX packet
        clear_all();
        for (int i = 0; i < 5; i++) rxq[1].push_back(rxw(i == 4, 2'd0, $urandom()));
        tx_stream = '{req(1, 1)};
        for (int c = 0; c < 20 && got_rx.size() < 2; c++) step();
        check("rst_two_words", got_rx.size(), 32'd2);
        @(negedge clk);
        drive();
        reset_n = 1'b0;
        #1;
        check("rst_outputs_immediate", outs(), '0);
        @(negedge clk);
        drive();
        #1;
        check("rst_outputs_held", outs(), '0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) step();
        check("rst_idle_no_rx", {got_rx.size(), rxq[1].size()}, {32'd2, 32'd3});
        clear_all();
        tx_stream = '{req(0, 0), dat(1, 2'd1, $urandom())};
        run_and_check("post_reset", 50);

        // Randomized mixed stream with random stalls
        clear_all();
        stall_pct = 25;
        for (int it = 0; it < 40; it++) begin
            kind = int'($urandom_range(5));
            qid  = int'($urandom_range(N - 1));
            len  = int'($urandom_range(1, 6));
            case (kind)
                0, 1: begin
                    tx_stream.push_back(req(0, qid));
                    for (int j = 0; j < len; j++)
                        tx_stream.push_back(dat(j == len - 1, 2'($urandom()), $urandom()));
                end
                2: begin
                    tx_stream.push_back(req(1, qid));
                    for (int j = 0; j < len; j++)
                        rxq[qid].push_back(rxw(j == len - 1, 2'($urandom()), $urandom()));
                end
                3: begin
                    tx_stream.push_back(req(kind[0] ^ $urandom_range(1) == 1, int'($urandom_range(N, 15))));
                    for (int j = 0; j < len % 3; j++)
                        tx_stream.push_back(dat(j == len % 3 - 1, 2'd0, $urandom()));
                end
                4: tx_stream.push_back(dat($urandom_range(1) == 1, 2'd0, $urandom()));
                default: begin
                    tx_stream.push_back(req(0, qid));
                    for (int j = 0; j < (len % 2) + 1; j++)
                        tx_stream.push_back(dat(0, 2'd0, $urandom()));
                end
            endcase
        end
        tx_stream.push_back(req(0, 1));
        tx_stream.push_back(dat(0, 2'd0, $urandom()));
        tx_stream.push_back(dat(1, 2'd3, $urandom()));
        run_and_check("random", 4000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
